// File: rtl/ac_outbuf_packer_pkg.sv
// ac_outbuf_packer_pkg: shared constants and width helpers for the output buffer packer.
// Holds the statistics counter width and the helpers used to derive counter and
// beat widths from the packer parameters.
package ac_outbuf_packer_pkg;

    localparam int STATS_W = 32;

    // $clog2 that never returns 0, so a counter with a range of 1 still has a bit
    function automatic int clog2_1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ac_outbuf_packer_fifo.sv
// ac_outbuf_packer_fifo: synchronous show-ahead FIFO with a flop-based store.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous flush
//   i_push      write i_data (ignored when full)
//   i_pop       drop the head entry (ignored when empty)
//   o_data      head entry, valid whenever o_level != 0
//   o_level     current occupancy 0..DEPTH
module ac_outbuf_packer_fifo
    import ac_outbuf_packer_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int AW    = clog2_1(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & (r_level != FULL);
    assign w_pop   = i_pop & (r_level != '0);
    assign o_data  = r_mem[r_rd];
    assign o_level = r_level;

    // The store is reset so the head reads as zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (clr) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_mem[r_wr] <= i_data;
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

endmodule

// File: rtl/ac_outbuf_packer.sv
// ac_outbuf_packer: packs UPSP write packets into AXI-Stream beats of N_PARALLEL packets.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clr                  synchronous soft clear (drops partial beat, flushes FIFO)
//   in_valid/in_data     input packet, pixel 0 in the LSBs; in_ready accepts it
//   m_t*                 AXI-Stream master: tdata/tkeep, tlast = row end, tuser = frame start
//   frame_done           one-cycle pulse after the last beat of a frame is queued
// Optional (macro AC_OUTBUF_PACKER_STATS_EN):
//   stall_cnt            saturating count of cycles with m_tvalid & ~m_tready
//   beat_cnt             wrapping count of popped beats
//   max_level            FIFO occupancy high-water mark
module ac_outbuf_packer
    import ac_outbuf_packer_pkg::*;
#(
    parameter int PIX_W      = 24,
    parameter int N_PIX_IN   = 1,
    parameter int N_PARALLEL = 4,
    parameter int IMG_W      = 4096,
    parameter int IMG_H      = 2160,
    parameter int FIFO_DEPTH = 16
)(
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      clr,
    input  logic                                      in_valid,
    input  logic [PIX_W*N_PIX_IN-1:0]                 in_data,
    output logic                                      in_ready,
    output logic                                      m_tvalid,
    input  logic                                      m_tready,
    output logic [PIX_W*N_PIX_IN*N_PARALLEL-1:0]      m_tdata,
    output logic [PIX_W*N_PIX_IN*N_PARALLEL/8-1:0]    m_tkeep,
    output logic                                      m_tlast,
    output logic                                      m_tuser,
    output logic                                      frame_done
`ifdef AC_OUTBUF_PACKER_STATS_EN
    ,
    output logic [STATS_W-1:0]                        stall_cnt,
    output logic [STATS_W-1:0]                        beat_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]           max_level
`endif
);

    localparam int PKT_W         = PIX_W * N_PIX_IN;
    localparam int OUT_W         = PKT_W * N_PARALLEL;
    localparam int KEEP_W        = OUT_W / 8;
    localparam int PKT_PER_ROW   = IMG_W / N_PIX_IN;
    localparam int BEATS_PER_ROW = ceil_div(PKT_PER_ROW, N_PARALLEL);
    localparam int LAST_LANES    = PKT_PER_ROW - (BEATS_PER_ROW - 1) * N_PARALLEL;
    localparam int LANE_W        = clog2_1(N_PARALLEL);
    localparam int PKT_CW        = clog2_1(PKT_PER_ROW);
    localparam int ROW_W         = clog2_1(IMG_H);
    localparam int LVL_W         = $clog2(FIFO_DEPTH + 1);
    localparam int FW            = OUT_W + KEEP_W + 2;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N_PARALLEL - 1);
    localparam logic [PKT_CW-1:0] PKT_LAST  = PKT_CW'(PKT_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [LVL_W-1:0]  FULL      = LVL_W'(FIFO_DEPTH);
    localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LAST_LANES * PKT_W / 8);

    logic              r_live;
    logic [LANE_W-1:0] r_lane;
    logic [PKT_CW-1:0] r_pkt;
    logic [ROW_W-1:0]  r_row;
    logic              r_first;
    logic              r_frame_done;
    logic [OUT_W-1:0]  r_acc;

    logic              w_acc;
    logic              w_row_end;
    logic              w_beat_end;
    logic              w_push;
    logic              w_user;
    logic [OUT_W-1:0]  w_merged;
    logic [KEEP_W-1:0] w_keep;
    logic [LVL_W-1:0]  w_level;
    logic [FW-1:0]     w_fifo_out;

    // r_live keeps in_ready low until the first clock after reset release
    assign in_ready   = r_live & (w_level != FULL) & ~clr;
    assign m_tvalid   = w_level != '0;
    assign w_acc      = in_valid & in_ready;
    assign w_row_end  = r_pkt == PKT_LAST;
    assign w_beat_end = w_row_end | (r_lane == LANE_LAST);
    assign w_push     = w_acc & w_beat_end;
    // Lanes above r_lane are still zero, so OR-ing the shifted packet is a merge
    assign w_merged   = r_acc | (OUT_W'(in_data) << (r_lane * PKT_W));
    assign w_keep     = w_row_end ? LAST_KEEP : '1;
    assign w_user     = (r_row == '0) & r_first;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live       <= 1'b0;
            r_lane       <= '0;
            r_pkt        <= '0;
            r_row        <= '0;
            r_first      <= 1'b1;
            r_frame_done <= 1'b0;
            r_acc        <= '0;
        end else begin
            r_live       <= 1'b1;
            r_frame_done <= w_push & w_row_end & (r_row == ROW_LAST);
            if (clr) begin
                r_lane  <= '0;
                r_pkt   <= '0;
                r_row   <= '0;
                r_first <= 1'b1;
                r_acc   <= '0;
            end else if (w_acc) begin
                r_lane <= w_beat_end ? '0 : r_lane + 1'b1;
                r_acc  <= w_beat_end ? '0 : w_merged;
                if (w_row_end) begin
                    r_pkt   <= '0;
                    r_first <= 1'b1;
                    r_row   <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_pkt <= r_pkt + 1'b1;
                    if (w_beat_end) r_first <= 1'b0;
                end
            end
        end
    end

    ac_outbuf_packer_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .i_push  (w_push),
        .i_data  ({w_merged, w_keep, w_row_end, w_user}),
        .i_pop   (m_tvalid & m_tready),
        .o_data  (w_fifo_out),
        .o_level (w_level)
    );

    assign {m_tdata, m_tkeep, m_tlast, m_tuser} = w_fifo_out;

`ifdef AC_OUTBUF_PACKER_STATS_EN
    logic [STATS_W-1:0] r_stall;
    logic [STATS_W-1:0] r_beats;
    logic [LVL_W-1:0]   r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_beats <= '0;
            r_max   <= '0;
        end else if (clr) begin
            r_stall <= '0;
            r_beats <= '0;
            r_max   <= '0;
        end else begin
            if (m_tvalid & ~m_tready & ~(&r_stall)) r_stall <= r_stall + 1'b1;
            if (m_tvalid & m_tready) r_beats <= r_beats + 1'b1;
            if (w_level > r_max) r_max <= w_level;
        end
    end

    assign stall_cnt = r_stall;
    assign beat_cnt  = r_beats;
    assign max_level = r_max;
`endif

endmodule

// File: tb/tb_ac_outbuf_packer.sv
// tb_ac_outbuf_packer: scoreboard bench for ac_outbuf_packer.
// Instance a: IMG_W=8, IMG_H=2, FIFO_DEPTH=4 (full beats, backpressure, clr, stats).
// Instance b: IMG_W=10, IMG_H=2, FIFO_DEPTH=16 (partial beats, random ready/valid).
module tb_ac_outbuf_packer;

    typedef struct packed {
        logic [95:0] d;
        logic [11:0] k;
        logic        l;
        logic        u;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    beat_t qa[$];
    beat_t qb[$];

    logic        a_clr = 1'b0, a_iv = 1'b0, a_tr = 1'b1;
    logic [23:0] a_id = '0;
    logic        a_ir, a_tv, a_tl, a_tu, a_fd;
    logic [95:0] a_td;
    logic [11:0] a_tk;
    logic        b_clr = 1'b0, b_iv = 1'b0, b_tr = 1'b1;
    logic [23:0] b_id = '0;
    logic        b_ir, b_tv, b_tl, b_tu, b_fd;
    logic [95:0] b_td;
    logic [11:0] b_tk;
    bit          b_rand = 1'b0;
    int          a_fdn = 0, b_fdn = 0;
    beat_t       a_hold, b_hold, ea, eb;
    bit          a_hv = 1'b0, b_hv = 1'b0;
`ifdef AC_OUTBUF_PACKER_STATS_EN
    logic [31:0] a_stall, a_beats, b_stall, b_beats;
    logic [2:0]  a_maxl;
    logic [4:0]  b_maxl;
    bit          st_on = 1'b0;
    int          st_exp = 0;
    always @(negedge clk) if (st_on && a_tv && !a_tr) st_exp++;
`endif

    ac_outbuf_packer #(.PIX_W(24), .N_PIX_IN(1), .N_PARALLEL(4), .IMG_W(8), .IMG_H(2), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .m_tvalid(a_tv), .m_tready(a_tr), .m_tdata(a_td), .m_tkeep(a_tk), .m_tlast(a_tl), .m_tuser(a_tu),
`ifdef AC_OUTBUF_PACKER_STATS_EN
        .stall_cnt(a_stall), .beat_cnt(a_beats), .max_level(a_maxl),
`endif
        .frame_done(a_fd)
    );

    ac_outbuf_packer #(.PIX_W(24), .N_PIX_IN(1), .N_PARALLEL(4), .IMG_W(10), .IMG_H(2), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .m_tvalid(b_tv), .m_tready(b_tr), .m_tdata(b_td), .m_tkeep(b_tk), .m_tlast(b_tl), .m_tuser(b_tu),
`ifdef AC_OUTBUF_PACKER_STATS_EN
        .stall_cnt(b_stall), .beat_cnt(b_beats), .max_level(b_maxl),
`endif
        .frame_done(b_fd)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int p3, p2, p1, p0, input logic [11:0] k, input logic l, u);
        mk = {24'(p3), 24'(p2), 24'(p1), 24'(p0), k, l, u};
    endfunction

    // Reference beats for a 2-row frame of consecutive pixel values starting at base
    task automatic exp_frame(input bit b, input int base, input int w);
        beat_t e;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < w; c += 4) begin
                e = '0;
                for (int j = 0; j < 4 && c + j < w; j++) begin
                    e.d[j*24 +: 24] = 24'(base + r * w + c + j);
                    e.k[j*3 +: 3]   = 3'b111;
                end
                e.l = (c + 4 >= w);
                e.u = (r == 0 && c == 0);
                if (b) qb.push_back(e); else qa.push_back(e);
            end
    endtask

    // Called at posedge+1; returns at posedge+1 after the packet is accepted
    task automatic send(input bit b, input int d, input int gap);
        bit ok = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        if (b) begin b_iv = 1'b1; b_id = 24'(d); end
        else   begin a_iv = 1'b1; a_id = 24'(d); end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = b ? b_ir : a_ir;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        a_iv = 1'b0;
        b_iv = 1'b0;
    endtask

    task automatic drain(input bit b);
        for (int i = 0; i < 300 && (b ? qb.size() : qa.size()) != 0; i++) @(negedge clk);
        chk(b ? "b_drain_left" : "a_drain_left", 128'(b ? qb.size() : qa.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        b_tr = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_tv && a_hv) chk("a_stable_stall", 128'({a_td, a_tk, a_tl, a_tu}), 128'(a_hold));
            if (a_tv && a_tr) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_beat: got %0h, expected no beat", a_td);
                end else begin
                    ea = qa.pop_front();
                    chk("a_tdata", 128'(a_td), 128'(ea.d));
                    chk("a_keep_last_user", 128'({a_tk, a_tl, a_tu}), 128'({ea.k, ea.l, ea.u}));
                end
            end
            a_hv   = a_tv && !a_tr;
            a_hold = {a_td, a_tk, a_tl, a_tu};
            if (a_fd) a_fdn++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (b_tv && b_hv) chk("b_stable_stall", 128'({b_td, b_tk, b_tl, b_tu}), 128'(b_hold));
            if (b_tv && b_tr) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_beat: got %0h, expected no beat", b_td);
                end else begin
                    eb = qb.pop_front();
                    chk("b_tdata", 128'(b_td), 128'(eb.d));
                    chk("b_keep_last_user", 128'({b_tk, b_tl, b_tu}), 128'({eb.k, eb.l, eb.u}));
                end
            end
            b_hv   = b_tv && !b_tr;
            b_hold = {b_td, b_tk, b_tl, b_tu};
            if (b_fd) b_fdn++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_a_ctl", 128'({a_tv, a_ir, a_fd, a_tl, a_tu}), 128'(0));
        chk("rst_a_tdata", 128'(a_td), 128'(0));
        chk("rst_a_tkeep", 128'(a_tk), 128'(0));
        chk("rst_b_ctl", 128'({b_tv, b_ir, b_fd, b_tl, b_tu}), 128'(0));
        chk("rst_b_tdata", 128'(b_td), 128'(0));
        chk("rst_b_tkeep", 128'(b_tk), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("a_in_ready_after_rst", 128'(a_ir), 128'(1));
        chk("b_in_ready_after_rst", 128'(b_ir), 128'(1));
        @(posedge clk);
        #1;

        // Full-width frame, pixels 1..16
        qa.push_back(mk(4, 3, 2, 1, 12'hFFF, 1'b0, 1'b1));
        qa.push_back(mk(8, 7, 6, 5, 12'hFFF, 1'b1, 1'b0));
        qa.push_back(mk(12, 11, 10, 9, 12'hFFF, 1'b0, 1'b0));
        qa.push_back(mk(16, 15, 14, 13, 12'hFFF, 1'b1, 1'b0));
        for (int i = 1; i <= 16; i++) begin
            send(1'b0, i, 0);
            if (i == 4) begin
                @(negedge clk);
                chk("a_first_beat_latency", 128'(a_tv), 128'(1));
                @(posedge clk);
                #1;
            end
        end
        drain(1'b0);
        chk("a_frame_done_1", 128'(a_fdn), 128'(1));

        // Backpressure: depth-4 FIFO fills with one frame, then drains
        a_tr = 1'b0;
        exp_frame(1'b0, 17, 8);
        for (int i = 0; i < 16; i++) send(1'b0, 17 + i, 0);
        @(negedge clk);
        chk("a_in_ready_full", 128'(a_ir), 128'(0));
        chk("a_tvalid_full", 128'(a_tv), 128'(1));
        repeat (5) @(posedge clk);
        #1 a_tr = 1'b1;
        drain(1'b0);
        chk("a_frame_done_2", 128'(a_fdn), 128'(2));

        // Soft clear mid-frame: queued beats and the partial beat are discarded
        a_tr = 1'b0;
        for (int i = 0; i < 10; i++) send(1'b0, 'h300 + i, 0);
        a_clr = 1'b1;
        @(negedge clk);
        chk("a_in_ready_in_clr", 128'(a_ir), 128'(0));
        @(posedge clk);
        #1 a_clr = 1'b0;
        @(negedge clk);
        chk("a_tvalid_after_clr", 128'(a_tv), 128'(0));
        @(posedge clk);
        #1 a_tr = 1'b1;
        qa.push_back(mk('hB4, 'hB3, 'hB2, 'hB1, 12'hFFF, 1'b0, 1'b1));
        for (int i = 0; i < 4; i++) send(1'b0, 'hB1 + i, 0);
        drain(1'b0);
        chk("a_frame_done_after_clr", 128'(a_fdn), 128'(2));

        // Partial row-end beats, pixels 1..20 over two 10-pixel rows
        qb.push_back(mk(4, 3, 2, 1, 12'hFFF, 1'b0, 1'b1));
        qb.push_back(mk(8, 7, 6, 5, 12'hFFF, 1'b0, 1'b0));
        qb.push_back(mk(0, 0, 10, 9, 12'h03F, 1'b1, 1'b0));
        qb.push_back(mk(14, 13, 12, 11, 12'hFFF, 1'b0, 1'b0));
        qb.push_back(mk(18, 17, 16, 15, 12'hFFF, 1'b0, 1'b0));
        qb.push_back(mk(0, 0, 20, 19, 12'h03F, 1'b1, 1'b0));
        for (int i = 1; i <= 20; i++) send(1'b1, i, 0);
        drain(1'b1);
        chk("b_frame_done_1", 128'(b_fdn), 128'(1));

        // Three frames with random input gaps and random tready
        b_rand = 1'b1;
        for (int f = 0; f < 3; f++) begin
            exp_frame(1'b1, 'h1000 + f * 20, 10);
            for (int i = 0; i < 20; i++) send(1'b1, 'h1000 + f * 20 + i, int'($urandom_range(0, 2)));
        end
        b_rand = 1'b0;
        drain(1'b1);
        chk("b_frame_done_4", 128'(b_fdn), 128'(4));

`ifdef AC_OUTBUF_PACKER_STATS_EN
        a_tr  = 1'b0;
        a_clr = 1'b1;
        @(posedge clk);
        #1 a_clr = 1'b0;
        st_on = 1'b1;
        exp_frame(1'b0, 'h500, 8);
        for (int i = 0; i < 16; i++) send(1'b0, 'h500 + i, 0);
        repeat (5) @(posedge clk);
        #1 a_tr = 1'b1;
        drain(1'b0);
        @(negedge clk);
        chk("a_stall_cnt", 128'(a_stall), 128'(st_exp));
        chk("a_beat_cnt", 128'(a_beats), 128'(4));
        chk("a_max_level", 128'(a_maxl), 128'(4));
        chk("b_beat_cnt", 128'(b_beats), 128'(24));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
